// File: rtl/ghpi_mem_responder.sv
// Word memory behind a valid/ack handshake with WAIT_STATES extra cycles per transfer.
// Optional range checking and sticky err_o when GHPI_RESP_BOUNDS_CHECK_EN is defined.

module ghpi_mem_lane #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk_i,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);
  logic [7:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk_i)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

module ghpi_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_LOG2  = 12,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic        valid_i,
  output logic        ack_o
`ifdef GHPI_RESP_BOUNDS_CHECK_EN
  ,
  output logic        err_o
`endif
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        we;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                         state, state_nxt;
  req_t                           req_q, req_cur;
  logic [3:0]                     cnt_q, cnt_nxt;
  logic [31:0]                    off_cur;
  logic [DEPTH_LOG2-1:0]          idx_cur;
  logic                           oob_cur;
  logic                           enter_resp, commit;
  logic [NUM_LANES-1:0]           lane_we;
  logic [NUM_LANES-1:0][VEC_W-1:0] rd_lanes;
  logic                           unused_off;

  // In IDLE the request is taken straight from the pins so a zero-wait read
  // can fetch on the same edge that latches it; afterwards only the latch counts.
  assign req_cur    = (state == S_IDLE) ? '{addr: addr_i, data: data_i, sel: sel_i, we: we_i} : req_q;
  assign off_cur    = req_cur.addr - BASE_ADDR;
  assign idx_cur    = off_cur[DEPTH_LOG2+1:2];
  assign unused_off = ^off_cur;

`ifdef GHPI_RESP_BOUNDS_CHECK_EN
  assign oob_cur = (off_cur >> (DEPTH_LOG2 + 2)) != 32'd0;
`else
  assign oob_cur = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    unique case (state)
      S_IDLE:
        if (valid_i) begin
          cnt_nxt   = 4'(WAIT_STATES);
          state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      S_WAIT:
        if (!valid_i) state_nxt = S_IDLE;
        else begin
          cnt_nxt = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_nxt = S_RESP;
        end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign enter_resp = (state_nxt == S_RESP);
  assign commit     = (state == S_RESP) && valid_i && req_q.we && !oob_cur;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_we[i] = commit && req_q.sel[i];
    ghpi_mem_lane #(.DEPTH_LOG2(DEPTH_LOG2)) u_lane (
      .clk_i (clk_i),
      .we    (lane_we[i]),
      .idx   (idx_cur),
      .wdata (req_q.data[i*VEC_W +: VEC_W]),
      .rdata (rd_lanes[i])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      cnt_q  <= 4'd0;
      ack_o  <= 1'b0;
      data_o <= 32'h0;
      req_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt_q <= cnt_nxt;
      ack_o <= enter_resp;
      if (state == S_IDLE && valid_i) req_q <= req_cur;
      if (enter_resp && !req_cur.we) data_o <= oob_cur ? 32'hDEAD_BEEF : rd_lanes;
    end
  end

`ifdef GHPI_RESP_BOUNDS_CHECK_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)                     err_o <= 1'b0;
    else if (enter_resp && oob_cur) err_o <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_ghpi_mem_responder.sv
// Bench for ghpi_mem_responder: zero-wait and three-wait instances checked every cycle
// against a transaction-count model, plus literal expectations for key scenarios.
`timescale 1ns/1ps
module tb_ghpi_mem_responder;
`ifdef GHPI_RESP_BOUNDS_CHECK_EN
  localparam int ND = 3;
`else
  localparam int ND = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr [ND];
  logic [31:0] wdat [ND];
  logic [31:0] rdat [ND];
  logic [3:0]  sel  [ND];
  logic        we   [ND];
  logic        vld  [ND];
  logic        ack  [ND];
`ifdef GHPI_RESP_BOUNDS_CHECK_EN
  logic        err  [ND];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ghpi_mem_responder #(.WAIT_STATES(0)) u0 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr[0]), .data_i(wdat[0]), .data_o(rdat[0]),
    .sel_i(sel[0]), .we_i(we[0]), .valid_i(vld[0]), .ack_o(ack[0])
`ifdef GHPI_RESP_BOUNDS_CHECK_EN
    , .err_o(err[0])
`endif
  );

  ghpi_mem_responder #(.WAIT_STATES(3)) u3 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr[1]), .data_i(wdat[1]), .data_o(rdat[1]),
    .sel_i(sel[1]), .we_i(we[1]), .valid_i(vld[1]), .ack_o(ack[1])
`ifdef GHPI_RESP_BOUNDS_CHECK_EN
    , .err_o(err[1])
`endif
  );

`ifdef GHPI_RESP_BOUNDS_CHECK_EN
  ghpi_mem_responder #(.DEPTH_LOG2(4), .BASE_ADDR(32'h0)) ub (
    .clk_i(clk), .rst_i(rst), .addr_i(addr[2]), .data_i(wdat[2]), .data_o(rdat[2]),
    .sel_i(sel[2]), .we_i(we[2]), .valid_i(vld[2]), .ack_o(ack[2]), .err_o(err[2])
  );
`endif

  function automatic int ws_of(input int d);
    return (d == 1) ? 3 : 0;
  endfunction

  function automatic int dl2_of(input int d);
    return (d == 2) ? 4 : 12;
  endfunction

  // Model: ph = -1 when free, otherwise cycles since the request was accepted;
  // the response cycle is ph == ws+1.
  int          ph     [ND];
  logic [31:0] m_a    [ND];
  logic [31:0] m_d    [ND];
  logic [3:0]  m_s    [ND];
  logic        m_w    [ND];
  logic [31:0] exp_rd [ND];
  logic        exp_err[ND];
  logic [31:0] mdl_mem [int];
  bit          chk_en = 1'b0;

  function automatic bit m_oob(input int d);
`ifdef GHPI_RESP_BOUNDS_CHECK_EN
    return m_a[d] >= (32'd4 << dl2_of(d));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_key(input int d);
    return d * 65536 + int'((m_a[d] >> 2) & ((32'd1 << dl2_of(d)) - 1));
  endfunction

  initial for (int d = 0; d < ND; d++) begin
    ph[d] = -1; exp_rd[d] = 32'h0; exp_err[d] = 1'b0;
    m_a[d] = '0; m_d[d] = '0; m_s[d] = '0; m_w[d] = 1'b0;
  end

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      int w;
      logic [31:0] old;
      w = ws_of(d);
      if (chk_en) begin
        checks++;
        if (ack[d] !== (ph[d] == w + 1)) begin
          errors++;
          $display("FAIL ack dut%0d t=%0t got %b want %b", d, $time, ack[d], (ph[d] == w + 1));
        end
        checks++;
        if (rdat[d] !== exp_rd[d]) begin
          errors++;
          $display("FAIL data_o dut%0d t=%0t got %h want %h", d, $time, rdat[d], exp_rd[d]);
        end
`ifdef GHPI_RESP_BOUNDS_CHECK_EN
        checks++;
        if (err[d] !== exp_err[d]) begin
          errors++;
          $display("FAIL err_o dut%0d t=%0t got %b want %b", d, $time, err[d], exp_err[d]);
        end
`endif
      end
      if (rst) begin
        ph[d] = -1; exp_rd[d] = 32'h0; exp_err[d] = 1'b0;
      end else if (ph[d] == -1) begin
        if (vld[d]) begin
          m_a[d] = addr[d]; m_d[d] = wdat[d]; m_s[d] = sel[d]; m_w[d] = we[d];
          ph[d] = 1;
        end
      end else if (!vld[d]) begin
        ph[d] = -1;
      end else if (ph[d] == w + 1) begin
        if (m_w[d] && !m_oob(d)) begin
          old = mdl_mem.exists(m_key(d)) ? mdl_mem[m_key(d)] : 32'hx;
          for (int i = 0; i < 4; i++) if (m_s[d][i]) old[8*i +: 8] = m_d[d][8*i +: 8];
          mdl_mem[m_key(d)] = old;
        end
        ph[d] = -1;
      end else begin
        ph[d]++;
      end
      if (ph[d] == w + 1) begin
        if (m_oob(d)) begin
          exp_err[d] = 1'b1;
          if (!m_w[d]) exp_rd[d] = 32'hDEAD_BEEF;
        end else if (!m_w[d]) begin
          exp_rd[d] = mdl_mem.exists(m_key(d)) ? mdl_mem[m_key(d)] : 32'hx;
        end
      end
    end
    chk_en = 1'b1;
  end

  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  // Called at posedge+1; holds valid until ack, then drops it one cycle later.
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] dat,
                      input logic [3:0] s, input bit scr, output logic [31:0] rd, output int lat);
    addr[d] = a; wdat[d] = dat; sel[d] = s; we[d] = w; vld[d] = 1'b1; lat = -1;
    for (int n = 0; n <= 20; n++) begin
      @(negedge clk);
      if (ack[d]) begin lat = n; break; end
      @(posedge clk); #1;
      if (scr) begin addr[d] = $urandom; wdat[d] = $urandom; sel[d] = 4'($urandom); end
    end
    rd = rdat[d];
    @(posedge clk); #1;
    vld[d] = 1'b0;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL timeout dut%0d addr %h no ack within 20 cycles", d, a);
    end
  endtask

  task automatic abort_after(input int d, input logic w, input logic [31:0] a,
                             input logic [31:0] dat, input int k);
    addr[d] = a; wdat[d] = dat; sel[d] = 4'hF; we[d] = w; vld[d] = 1'b1;
    repeat (k) @(posedge clk);
    #1 vld[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  int          lat;
  logic [31:0] v10;

  initial begin
    for (int d = 0; d < ND; d++) begin
      addr[d] = '0; wdat[d] = '0; sel[d] = '0; we[d] = 1'b0; vld[d] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    lit("reset_ack", {31'd0, ack[1]}, 32'd0);
    lit("reset_data", rdat[1], 32'h0);
    rst = 1'b0;

    // zero-wait write then read, first request right after reset
    xfer(0, 1'b1, 32'h10, 32'h1234_5678, 4'hF, 1'b0, rd, lat);
    lit("w_lat_ws0", 32'(lat), 32'd1);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, rd, lat);
    lit("r_lat_ws0", 32'(lat), 32'd1);
    lit("rd_0x10", rd, 32'h1234_5678);

    // single-lane write into an existing word
    xfer(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'hF, 1'b0, rd, lat);
    xfer(0, 1'b1, 32'h21, 32'h0000_EE00, 4'b0010, 1'b0, rd, lat);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, rd, lat);
    lit("rd_lane1", rd, 32'hAABB_EEDD);

    // sel=0 acks but writes nothing
    xfer(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 1'b0, rd, lat);
    lit("sel0_lat", 32'(lat), 32'd1);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, rd, lat);
    lit("rd_sel0", rd, 32'h1234_5678);
    v10 = 32'h1234_5678;

`ifndef GHPI_RESP_BOUNDS_CHECK_EN
    // index wraps modulo depth: 0x4010 aliases 0x10
    xfer(0, 1'b1, 32'h4010, 32'hCAFE_F00D, 4'hF, 1'b0, rd, lat);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, rd, lat);
    lit("rd_wrap", rd, 32'hCAFE_F00D);
    v10 = 32'hCAFE_F00D;
`endif

    // valid dropped during the response cycle: no write
    abort_after(0, 1'b1, 32'h10, 32'h0BAD_BEEF, 1);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, rd, lat);
    lit("rd_abort_resp", rd, v10);

    // three wait states, inputs scrambled after latching
    xfer(1, 1'b1, 32'h40, 32'h0102_0304, 4'hF, 1'b1, rd, lat);
    lit("w_lat_ws3", 32'(lat), 32'd4);
    xfer(1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b1, rd, lat);
    lit("r_lat_ws3", 32'(lat), 32'd4);
    lit("rd_0x40_ws3", rd, 32'h0102_0304);

    // abort during WAIT
    abort_after(1, 1'b1, 32'h40, 32'hFFFF_FFFF, 2);
    xfer(1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, rd, lat);
    lit("rd_abort_wait", rd, 32'h0102_0304);

    // reset during WAIT of a write
    xfer(1, 1'b1, 32'h50, 32'h5566_7788, 4'hF, 1'b0, rd, lat);
    addr[1] = 32'h50; wdat[1] = 32'hDEAD_DEAD; sel[1] = 4'hF; we[1] = 1'b1; vld[1] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; vld[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    lit("rst_ack", {31'd0, ack[1]}, 32'd0);
    lit("rst_data", rdat[1], 32'h0);
    xfer(1, 1'b0, 32'h50, 32'h0, 4'hF, 1'b0, rd, lat);
    lit("post_rst_lat", 32'(lat), 32'd4);
    lit("post_rst_rd", rd, 32'h5566_7788);

`ifdef GHPI_RESP_BOUNDS_CHECK_EN
    xfer(2, 1'b1, 32'h0, 32'hA5A5_A5A5, 4'hF, 1'b0, rd, lat);
    lit("err_before", {31'd0, err[2]}, 32'd0);
    xfer(2, 1'b1, 32'h40, 32'h1111_1111, 4'hF, 1'b0, rd, lat);
    lit("oob_w_lat", 32'(lat), 32'd1);
    xfer(2, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, rd, lat);
    lit("oob_rd", rd, 32'hDEAD_BEEF);
    lit("oob_err", {31'd0, err[2]}, 32'd1);
    xfer(2, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, rd, lat);
    lit("word0_kept", rd, 32'hA5A5_A5A5);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/ghpi_mem_responder.md
GHPI_MEM_RESPONDER -- requirements
Module: ghpi_mem_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-002 Parameter DEPTH_LOG2, default 12: memory holds 2**DEPTH_LOG2 32-bit words.
REQ-003 Parameter WAIT_STATES, default 0, legal 0..15: extra cycles inserted before ack.
REQ-004 clk_i  input  1  clock; all state changes on the rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 addr_i  input  32  byte address from master; bits [1:0] ignored.
REQ-007 data_i  input  32  write data from master.
REQ-008 data_o  output  32  read data to master.
REQ-009 sel_i  input  4  byte-lane enables; bit n covers data bits [8n+7:8n].
REQ-010 we_i  input  1  1 = write, 0 = read.
REQ-011 valid_i  input  1  master request valid.
REQ-012 ack_o  output  1  responder acknowledge; a transfer completes on a cycle with valid_i && ack_o.
REQ-013 err_o  output  1  sticky out-of-range flag (present only with GHPI_RESP_BOUNDS_CHECK_EN).

Function
REQ-014 Three-state FSM: IDLE, WAIT, RESP; reset state IDLE.
REQ-015 IDLE with valid_i=1: latch addr_i, data_i, sel_i, we_i; load wait counter with WAIT_STATES; go to WAIT if WAIT_STATES>0, else RESP.
REQ-016 WAIT: decrement counter each cycle; at counter==1, go to RESP.
REQ-017 ack_o is registered: 1 only in RESP, for exactly one cycle; latency from first valid_i sample to ack_o = WAIT_STATES+1 cycles.
REQ-018 RESP always returns to IDLE; a valid_i still high in the following IDLE cycle starts a new transaction (back-to-back throughput of one transfer per WAIT_STATES+2 cycles).
REQ-019 Read: on entry to RESP, data_o loads mem[latched word index]; data_o holds that value until the next read completes.
REQ-020 Write: commit at the clock edge ending RESP, only if valid_i=1 in RESP; write only the lanes set in latched sel; unselected lanes unchanged; sel=4'b0000 writes nothing but still acks.
REQ-021 Word index = (latched addr - BASE_ADDR) >> 2, truncated to DEPTH_LOG2 bits (wraps modulo depth when bounds check is disabled).
REQ-022 valid_i deasserted in WAIT or RESP: abort to IDLE next cycle, no write committed, data_o unchanged.
REQ-023 Changes on addr_i/data_i/sel_i/we_i after latching are ignored for the current transaction.
REQ-024 Read and write never occur in the same transaction; no read-modify-write beyond lane masking.

Reset
REQ-025 rst_i=1: FSM to IDLE, ack_o=0, data_o=32'h0, wait counter=0, err_o=0; any in-flight transaction dropped without write.
REQ-026 Memory array contents are not cleared by reset.
REQ-027 First request is accepted in the first cycle after rst_i deasserts.

Configuration
REQ-028 Macro GHPI_RESP_BOUNDS_CHECK_EN defined: an access with (addr - BASE_ADDR) >= 4*2**DEPTH_LOG2 (unsigned) still acks on schedule, writes are suppressed, reads return 32'hDEAD_BEEF, and err_o sets to 1 and stays until reset.
REQ-029 Macro undefined: no range check, err_o port absent, index wraps per REQ-021.

Verification
REQ-030 WAIT_STATES=0; write 32'h1234_5678 sel=4'hF to 0x10, then read 0x10 -> each ack_o one cycle after valid_i, read data_o=32'h1234_5678.
REQ-031 Word 0x20 = 32'hAABB_CCDD; write 32'h0000_EE00 sel=4'b0010 to 0x21 -> read 0x20 returns 32'hAABB_EEDD.
REQ-032 WAIT_STATES=3; read held valid -> ack_o high exactly cycle 4 after first valid sample, low cycles 1-3 and 5.
REQ-033 WAIT_STATES=3; write 32'hFFFF_FFFF to 0x40, drop valid_i after 2 cycles -> no ack_o, subsequent read of 0x40 returns the old value.
REQ-034 rst_i pulsed in WAIT of a write -> ack_o=0, data_o=0, target word unchanged, new read accepted the cycle after reset releases.
REQ-035 With GHPI_RESP_BOUNDS_CHECK_EN, DEPTH_LOG2=4, BASE_ADDR=0; write to 0x40 then read 0x40 -> both ack, read returns 32'hDEAD_BEEF, err_o=1, word 0 unchanged.
